// File: rtl/poly_note_player_pkg.sv
// Shared definitions for the polyphonic note player: voice index width,
// mix FSM encoding and the rest note code.
package poly_note_player_pkg;

    localparam int NOTE_W  = 6;
    localparam int SINE_AW = 10;
    localparam logic [NOTE_W-1:0] REST_NOTE = 6'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_PHASE,
        S_ACC,
        S_DONE
    } mix_state_t;

    // A single voice still needs a 1-bit index port.
    function automatic int vidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frequency_rom.sv
// Note-to-phase-step table, one-cycle registered read.
// Step grows linearly with the note code; note 0 (rest) yields step 0.
module frequency_rom #(
    parameter int STEP_W = 20
) (
    input  logic              clk,
    input  logic [5:0]        addr,
    output logic [STEP_W-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= STEP_W'({addr, 12'd0});
    end

endmodule

// File: rtl/poly_voice_bank.sv
// Per-voice note, duration and phase state with load/beat handling.
// One read/update port, indexed by the mix FSM, serves the phase accumulators.
module poly_voice_bank
    import poly_note_player_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DUR_W      = 6,
    parameter int PHASE_W    = 22,
    parameter int VIDX_W     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  play_enable,
    input  logic                  load_new_note,
    input  logic [VIDX_W-1:0]     load_voice,
    input  logic [NOTE_W-1:0]     note_to_load,
    input  logic [DUR_W-1:0]      duration_to_load,
    input  logic                  beat,
    input  logic [VIDX_W-1:0]     rd_voice,
    output logic [NOTE_W-1:0]     rd_note,
    output logic [PHASE_W-1:0]    rd_phase,
    output logic                  rd_active,
    input  logic                  ph_wr_en,
    input  logic [PHASE_W-1:0]    ph_wr_data,
    output logic [NUM_VOICES-1:0] voice_active
);

    logic [NUM_VOICES-1:0][NOTE_W-1:0]  note_v;
    logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_v;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [NOTE_W-1:0]  note_q;
        logic [DUR_W-1:0]   dur_q;
        logic [PHASE_W-1:0] phase_q;
        logic               ld, sel;

        assign ld  = load_new_note && (load_voice == VIDX_W'(v));
        assign sel = rd_voice == VIDX_W'(v);

        // A load overrides both a same-cycle beat and a same-cycle phase write.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                note_q  <= REST_NOTE;
                dur_q   <= '0;
                phase_q <= '0;
            end else if (ld) begin
                note_q  <= note_to_load;
                dur_q   <= duration_to_load;
                phase_q <= '0;
            end else begin
                if (beat && play_enable && dur_q != '0)
                    dur_q <= dur_q - 1'b1;
                if (ph_wr_en && sel)
                    phase_q <= ph_wr_data;
            end
        end

        assign note_v[v]       = note_q;
        assign phase_v[v]      = phase_q;
        assign voice_active[v] = (note_q != REST_NOTE) && (dur_q != '0);
    end

    assign rd_note   = note_v[rd_voice];
    assign rd_phase  = phase_v[rd_voice];
    assign rd_active = voice_active[rd_voice];

endmodule

// File: rtl/sine_rom.sv
// Piecewise-linear sine approximation, one-cycle registered read.
// Quarter-wave magnitude is mirrored by addr[8] and negated by addr[9].
module sine_rom #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic [9:0]               addr,
    output logic signed [DATA_W-1:0] dout
);

    localparam int SLOPE = (1 << (DATA_W - 9)) - 1;

    logic [8:0]               mag_idx;
    logic signed [DATA_W-1:0] mag;

    always_comb begin
        mag_idx = addr[8] ? (9'd256 - {1'b0, addr[7:0]}) : {1'b0, addr[7:0]};
        mag     = DATA_W'(int'(mag_idx) * SLOPE);
    end

    always_ff @(posedge clk) begin
        dout <= addr[9] ? -mag : mag;
    end

endmodule

// File: rtl/poly_note_player.sv
// Time-multiplexed polyphonic player: walks all voices per codec request and mixes them.
// POLY_NOTE_PLAYER_SAT_EN selects saturating (unscaled) output instead of the 1/NUM_VOICES mix.
module poly_note_player
    import poly_note_player_pkg::*;
#(
    parameter int  NUM_VOICES = 4,
    parameter int  DUR_W      = 6,
    parameter int  SAMPLE_W   = 16,
    parameter int  PHASE_W    = 22,
    localparam int VIDX_W     = vidx_w(NUM_VOICES)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       play_enable,
    input  logic                       load_new_note,
    input  logic [VIDX_W-1:0]          load_voice,
    input  logic [NOTE_W-1:0]          note_to_load,
    input  logic [DUR_W-1:0]           duration_to_load,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_ready,
    output logic [NUM_VOICES-1:0]      voice_active,
    output logic                       busy
);

    localparam int ACC_W  = SAMPLE_W + VIDX_W;
    localparam int STEP_W = 20;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 <<< (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 <<< (SAMPLE_W - 1)));

    mix_state_t                 state, state_nxt;
    logic [VIDX_W-1:0]          v_idx;
    logic                       last_voice, mix_en, ph_wr_en, rd_active;
    logic [NOTE_W-1:0]          rd_note;
    logic [PHASE_W-1:0]         rd_phase, phase_sum;
    logic [STEP_W-1:0]          step;
    logic signed [SAMPLE_W-1:0] sine, mixed;
    logic signed [ACC_W-1:0]    sine_ext, acc, acc_nxt;

    poly_voice_bank #(
        .NUM_VOICES(NUM_VOICES), .DUR_W(DUR_W), .PHASE_W(PHASE_W), .VIDX_W(VIDX_W)
    ) u_bank (
        .clk, .reset_n, .play_enable, .load_new_note, .load_voice, .note_to_load,
        .duration_to_load, .beat,
        .rd_voice   (v_idx),
        .rd_note    (rd_note),
        .rd_phase   (rd_phase),
        .rd_active  (rd_active),
        .ph_wr_en   (ph_wr_en),
        .ph_wr_data (phase_sum),
        .voice_active
    );

    frequency_rom #(.STEP_W(STEP_W)) u_freq (.clk, .addr(rd_note), .dout(step));
    sine_rom #(.DATA_W(SAMPLE_W)) u_sine (.clk, .addr(phase_sum[PHASE_W-1 -: SINE_AW]), .dout(sine));

    assign last_voice = v_idx == VIDX_W'(NUM_VOICES - 1);
    assign mix_en     = rd_active && play_enable;
    assign phase_sum  = rd_phase + PHASE_W'(step);
    assign ph_wr_en   = (state == S_PHASE) && mix_en;
    assign sine_ext   = {{VIDX_W{sine[SAMPLE_W-1]}}, sine};
    assign sample_ready = state == S_DONE;
    assign busy         = state != S_IDLE;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        case (state)
            S_IDLE:  if (generate_next_sample) state_nxt = S_STEP;
            S_STEP:  state_nxt = S_PHASE;
            S_PHASE: state_nxt = S_ACC;
            S_ACC: begin
                acc_nxt   = acc + (mix_en ? sine_ext : '0);
                state_nxt = last_voice ? S_DONE : S_STEP;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef POLY_NOTE_PLAYER_SAT_EN
        if (acc_nxt > OUT_MAX)      mixed = SAMPLE_W'(OUT_MAX);
        else if (acc_nxt < OUT_MIN) mixed = SAMPLE_W'(OUT_MIN);
        else                        mixed = SAMPLE_W'(acc_nxt);
`else
        mixed = SAMPLE_W'(acc_nxt >>> VIDX_W);
`endif
    end

    // sample_out is loaded on the last ACC so it is already valid while sample_ready is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            v_idx      <= '0;
            acc        <= '0;
            sample_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && generate_next_sample) begin
                acc   <= '0;
                v_idx <= '0;
            end else if (state == S_ACC) begin
                acc <= acc_nxt;
                if (last_voice) sample_out <= mixed;
                else            v_idx      <= v_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_poly_note_player.sv
// Directed self-checking bench for poly_note_player (4 voices, default widths).
// Expected samples come from hand-evaluated ROM contents; honours POLY_NOTE_PLAYER_SAT_EN.
module tb_poly_note_player;

`ifdef POLY_NOTE_PLAYER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               play_enable, load_new_note, beat, generate_next_sample;
    logic [1:0]         load_voice;
    logic [5:0]         note_to_load;
    logic [5:0]         duration_to_load;
    logic signed [15:0] sample_out;
    logic               sample_ready, busy;
    logic [3:0]         voice_active;

    int errors = 0;
    int checks = 0;

    poly_note_player dut (
        .clk(clk), .reset_n(reset_n), .play_enable(play_enable),
        .load_new_note(load_new_note), .load_voice(load_voice),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .beat(beat), .generate_next_sample(generate_next_sample),
        .sample_out(sample_out), .sample_ready(sample_ready),
        .voice_active(voice_active), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        play_enable = 1'b1; load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
        load_voice = '0; note_to_load = '0; duration_to_load = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load(input logic [1:0] v, input logic [5:0] n, input logic [5:0] d, input logic with_beat);
        @(negedge clk);
        load_new_note = 1'b1; load_voice = v; note_to_load = n; duration_to_load = d; beat = with_beat;
        @(negedge clk);
        load_new_note = 1'b0; beat = 1'b0;
    endtask

    task automatic pulse_beat();
        @(negedge clk);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
    endtask

    // Issues one request and waits (bounded) for sample_ready; lat counts cycles after the request.
    task automatic request(output logic signed [15:0] s, output int lat);
        @(negedge clk);
        generate_next_sample = 1'b1;
        @(negedge clk);
        generate_next_sample = 1'b0;
        lat = 1;
        while (!sample_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = sample_out;
    endtask

    task automatic test_reset();
        int seen = 0;
        logic signed [15:0] s;
        int lat;
        do_reset();
        load(2'd0, 6'd49, 6'd4, 1'b0);
        @(negedge clk);
        generate_next_sample = 1'b1;
        @(negedge clk);
        generate_next_sample = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            generate_next_sample = i[0];
            @(negedge clk);
            if (sample_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_ready: pulses=%0d required 0", seen); end
        checks++;
        if (sample_out !== 16'sd0) begin errors++; $display("FAIL reset_sample: got %0d required 0", sample_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b required 0000", voice_active); end
        generate_next_sample = 1'b0;
        reset_n = 1'b1;
        request(s, lat);
        checks++;
        if (s !== 16'sd0) begin errors++; $display("FAIL reset_post_sample: got %0d required 0", s); end
    endtask

    task automatic test_latency();
        int pulses = 0;
        int first = -1;
        logic signed [15:0] s = '0;
        logic signed [15:0] exp_s;
        logic busy_seen = 1'b0;
        exp_s = SAT ? 16'sd6223 : 16'sd1555;
        do_reset();
        load(2'd0, 6'd49, 6'd4, 1'b0);
        @(negedge clk);
        generate_next_sample = 1'b1;
        for (int rel = 1; rel <= 30; rel++) begin
            @(negedge clk);
            if (sample_ready) begin
                pulses++;
                if (first < 0) begin first = rel; s = sample_out; end
            end
            if (rel == 1) busy_seen = busy;
            generate_next_sample = (rel == 2);
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL latency_pulses: got %0d required 1", pulses); end
        checks++;
        if (first !== 13) begin errors++; $display("FAIL latency_cycle: got %0d required 13", first); end
        checks++;
        if (busy_seen !== 1'b1) begin errors++; $display("FAIL latency_busy: got %b required 1", busy_seen); end
        checks++;
        if (s !== exp_s) begin errors++; $display("FAIL latency_sample: got %0d required %0d", s, exp_s); end
    endtask

    task automatic test_single_voice();
        logic signed [15:0] s;
        logic signed [15:0] exp_off [3] = '{16'sd1555, 16'sd3111, 16'sd4667};
        logic signed [15:0] exp_on  [3] = '{16'sd6223, 16'sd12446, 16'sd18669};
        int lat;
        do_reset();
        load(2'd0, 6'd49, 6'd4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            request(s, lat);
            checks++;
            if (s !== (SAT ? exp_on[k] : exp_off[k]) || lat !== 13) begin
                errors++;
                $display("FAIL single_req%0d: got %0d lat %0d required %0d lat 13",
                         k, s, lat, SAT ? exp_on[k] : exp_off[k]);
            end
        end
        // Phase holds while disabled and resumes afterwards.
        play_enable = 1'b0;
        request(s, lat);
        checks++;
        if (s !== 16'sd0) begin errors++; $display("FAIL play_off_sample: got %0d required 0", s); end
        play_enable = 1'b1;
        request(s, lat);
        checks++;
        if (s !== (SAT ? 16'sd24892 : 16'sd6223)) begin
            errors++; $display("FAIL play_resume: got %0d required %0d", s, SAT ? 24892 : 6223);
        end
    endtask

    task automatic test_negative();
        logic signed [15:0] s;
        int lat;
        do_reset();
        load(2'd3, 6'd63, 6'd20, 1'b0);
        for (int k = 0; k < 9; k++) request(s, lat);
        checks++;
        if (s !== (SAT ? -16'sd6985 : -16'sd1747)) begin
            errors++; $display("FAIL negative_sample: got %0d required %0d", s, SAT ? -6985 : -1747);
        end
    endtask

    task automatic test_duration();
        do_reset();
        load(2'd2, 6'd5, 6'd2, 1'b0);
        checks++;
        if (voice_active !== 4'b0100) begin errors++; $display("FAIL dur_loaded: got %b required 0100", voice_active); end
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0100) begin errors++; $display("FAIL dur_beat1: got %b required 0100", voice_active); end
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL dur_beat2: got %b required 0000", voice_active); end
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL dur_beat3_nowrap: got %b required 0000", voice_active); end
        load(2'd0, 6'd9, 6'd1, 1'b0);
        play_enable = 1'b0;
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0001) begin errors++; $display("FAIL dur_frozen: got %b required 0001", voice_active); end
        play_enable = 1'b1;
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL dur_unfrozen: got %b required 0000", voice_active); end
        load(2'd3, 6'd0, 6'd5, 1'b0);
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL dur_rest: got %b required 0000", voice_active); end
    endtask

    task automatic test_load_beat();
        do_reset();
        load(2'd1, 6'd7, 6'd3, 1'b1);
        pulse_beat();
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0010) begin errors++; $display("FAIL load_beat_two: got %b required 0010", voice_active); end
        pulse_beat();
        checks++;
        if (voice_active !== 4'b0000) begin errors++; $display("FAIL load_beat_three: got %b required 0000", voice_active); end
    endtask

    task automatic test_mix();
        logic signed [15:0] s;
        int lat;
        do_reset();
        for (int v = 0; v < 4; v++) load(2'(v), 6'd49, 6'd10, 1'b0);
        checks++;
        if (voice_active !== 4'b1111) begin errors++; $display("FAIL mix_active: got %b required 1111", voice_active); end
        request(s, lat);
        checks++;
        if (s !== (SAT ? 16'sd24892 : 16'sd6223)) begin
            errors++; $display("FAIL mix_first: got %0d required %0d", s, SAT ? 24892 : 6223);
        end
        request(s, lat);
        checks++;
        if (s !== (SAT ? 16'sh7FFF : 16'sd12446)) begin
            errors++; $display("FAIL mix_peak: got %0d required %0d", s, SAT ? 32767 : 12446);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_single_voice();
        test_negative();
        test_duration();
        test_load_beat();
        test_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
